// File: rtl/dac_tx.sv
// dac_tx -- serial DAC write master.
// Accepts a WIDTH-bit word on valid/ready, then drives an MSB-first frame on
// cs/sclk/sdo (cs active-low, sclk idles high, data launched on the falling
// edge), pulses ldac low for one half-period, flags done, and waits out an
// idle gap before accepting the next word. Every output comes straight from a
// flop.
module dac_tx #(
    parameter int unsigned HALF_PERIOD = 460,  // clk cycles per half SCLK period, >= 2
    parameter int unsigned WIDTH       = 16,   // bits per frame, >= 2
    parameter int unsigned GAP_HALVES  = 2     // idle half-periods after ldac, >= 1
) (
    input  logic             clk_80_mhz,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dac_value,
    input  logic             valid,
    output logic             ready,
    output logic             cs,
    output logic             sclk,
    output logic             sdo,
    output logic             ldac,
    output logic             done
);

    localparam int unsigned DIV_W   = $clog2(HALF_PERIOD);
    localparam int unsigned CNT_MAX = (WIDTH > GAP_HALVES) ? WIDTH : GAP_HALVES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_LOAD,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;     // bits left in SHIFT, gap halves left in GAP
    logic [WIDTH-1:0]   shreg_q, shreg_d; // bits still to be launched, next one at the top
    logic               ready_q, ready_d;
    logic               cs_q, cs_d;
    logic               sclk_q, sclk_d;
    logic               sdo_q, sdo_d;
    logic               ldac_q, ldac_d;
    logic               done_q, done_d;
    logic               tick;

    // Half-period boundary: the divider has reached its last count.
    assign tick = (div_q == DIV_W'(HALF_PERIOD - 1));

    // Register every piece of state; reset puts the pins in their idle levels.
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from the values sampled at the same edge.
    always_ff @(posedge clk_80_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            ready_q <= 1'b1;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            sdo_q   <= 1'b0;
            ldac_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ready_q <= ready_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            ldac_q  <= ldac_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    // NOTE: every signal gets a default before the case statement, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        ready_d = ready_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        sdo_d   = sdo_q;
        ldac_d  = ldac_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Divider held at zero so the first half-period starts at acceptance.
                div_d = '0;
                if (valid && ready_q) begin
                    shreg_d = {dac_value[WIDTH-2:0], 1'b0};
                    sdo_d   = dac_value[WIDTH-1];
                    cs_d    = 1'b0;
                    ready_d = 1'b0;
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                // First falling edge; the MSB is already on sdo.
                if (tick) begin
                    sclk_d  = 1'b0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: the DAC samples here; count the bit off.
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = S_HOLD;
                        end
                    end else begin
                        // Later falling edges launch the next lower bit.
                        sdo_d   = shreg_q[WIDTH-1];
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    end
                end
            end

            S_HOLD: begin
                // LSB has been held a full half-period past the last rise.
                if (tick) begin
                    cs_d    = 1'b1;
                    sdo_d   = 1'b0;
                    ldac_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (tick) begin
                    ldac_d  = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = CNT_W'(GAP_HALVES);
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                if (tick) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready = ready_q;
    assign cs    = cs_q;
    assign sclk  = sclk_q;
    assign sdo   = sdo_q;
    assign ldac  = ldac_q;
    assign done  = done_q;

endmodule

// File: tb/tb_dac_tx.sv
// tb_dac_tx -- bench for dac_tx.
// Two instances share clock and reset: instance 0 with HALF_PERIOD=4, instance
// 1 with HALF_PERIOD=2. A closed-form model gives every output as a function of
// the cycles elapsed since acceptance; a per-cycle compare checks both
// instances against it, and directed checks pin frame contents and durations
// to hand-computed numbers.
module tb_dac_tx;

    localparam int W = 16;
    localparam int G = 2;
    localparam int RDY = 5, CS = 4, SCK = 3, SDO = 2, LD = 1, DN = 0;
    localparam logic [5:0] IDLE_OUT = 6'b111010; // ready cs sclk sdo ldac done

    logic clk;
    logic rst_n;
    logic valid_a, valid_b;
    logic [W-1:0] data_a, data_b;
    logic ready_a, cs_a, sclk_a, sdo_a, ldac_a, done_a;
    logic ready_b, cs_b, sclk_b, sdo_b, ldac_b, done_b;

    dac_tx #(.HALF_PERIOD(4), .WIDTH(W), .GAP_HALVES(G)) dut_a (
        .clk_80_mhz(clk), .rst_n(rst_n), .dac_value(data_a), .valid(valid_a),
        .ready(ready_a), .cs(cs_a), .sclk(sclk_a), .sdo(sdo_a), .ldac(ldac_a), .done(done_a)
    );

    dac_tx #(.HALF_PERIOD(2), .WIDTH(W), .GAP_HALVES(G)) dut_b (
        .clk_80_mhz(clk), .rst_n(rst_n), .dac_value(data_b), .valid(valid_b),
        .ready(ready_b), .cs(cs_b), .sclk(sclk_b), .sdo(sdo_b), .ldac(ldac_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0]   out_v[2];
    logic         valid_v[2];
    logic [W-1:0] data_v[2];
    assign out_v[0]   = {ready_a, cs_a, sclk_a, sdo_a, ldac_a, done_a};
    assign out_v[1]   = {ready_b, cs_b, sclk_b, sdo_b, ldac_b, done_b};
    assign valid_v[0] = valid_a;
    assign valid_v[1] = valid_b;
    assign data_v[0]  = data_a;
    assign data_v[1]  = data_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Outputs t cycles after the acceptance edge of word w, half-period h.
    function automatic logic [5:0] exp_out(input int t, input logic [W-1:0] w, input int h);
        logic [5:0] o;
        int k;
        o[RDY] = (t >= (2*W + 2 + G) * h);
        o[CS]  = !(t < (2*W + 1) * h);
        o[SCK] = !(((t / h) % 2 == 1) && (t < 2*W*h));
        if (t < (2*W + 1) * h) begin
            k = (t + h) / (2 * h);
            if (k < 1) k = 1;
            if (k > W) k = W;
            o[SDO] = w[W-k];
        end else begin
            o[SDO] = 1'b0;
        end
        o[LD] = !((t >= (2*W + 1) * h) && (t < (2*W + 2) * h));
        o[DN] = (t == (2*W + 2) * h);
        return o;
    endfunction

    int           hp[2] = '{4, 2};
    logic         m_act[2];
    int           m_t[2];
    logic [W-1:0] m_word[2];

    always @(posedge clk) cyc++;

    // Model: a frame starts whenever valid is seen while the model is idle or
    // its previous frame has reached the ready point.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_act[i] = 1'b0;
                m_t[i]   = 0;
            end else if (!m_act[i] || m_t[i] >= (2*W + 2 + G) * hp[i]) begin
                if (valid_v[i]) begin
                    m_act[i]  = 1'b1;
                    m_t[i]    = 0;
                    m_word[i] = data_v[i];
                end else begin
                    m_act[i] = 1'b0;
                end
            end else begin
                m_t[i]++;
            end
        end
    end

    // Per-cycle compare of all outputs of both instances.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check(i == 0 ? "outputs_a" : "outputs_b", 32'(out_v[i]),
                  32'(m_act[i] ? exp_out(m_t[i], m_word[i], hp[i]) : IDLE_OUT));
        end
    end

    // ---------------- frame monitor ----------------
    logic         prev_cs[2]   = '{1'b1, 1'b1};
    logic         prev_sclk[2] = '{1'b1, 1'b1};
    logic         prev_rdy[2]  = '{1'b1, 1'b1};
    int           sclk_edges[2], fall_cyc[2], prev_fall[2], rise_cyc[2], rdy_cyc[2];
    int           cs_low[2], ldac_low[2], done_n[2], rises[2], last_rise[2], per[2];
    logic [W-1:0] cap[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (out_v[i][SCK] != prev_sclk[i]) sclk_edges[i]++;
            if (prev_cs[i] && !out_v[i][CS]) begin
                prev_fall[i] = fall_cyc[i];
                fall_cyc[i]  = cyc;
                cs_low[i]    = 0;
                ldac_low[i]  = 0;
                done_n[i]    = 0;
                rises[i]     = 0;
                cap[i]       = '0;
            end
            if (!prev_cs[i] && out_v[i][CS]) rise_cyc[i] = cyc;
            if (!prev_rdy[i] && out_v[i][RDY]) rdy_cyc[i] = cyc;
            if (!out_v[i][CS]) cs_low[i]++;
            if (!out_v[i][LD]) ldac_low[i]++;
            if (out_v[i][DN]) done_n[i]++;
            if (!prev_sclk[i] && out_v[i][SCK] && !out_v[i][CS]) begin
                if (rises[i] > 0) per[i] = cyc - last_rise[i];
                last_rise[i] = cyc;
                rises[i]++;
                cap[i] = {cap[i][W-2:0], out_v[i][SDO]};
            end
            prev_cs[i]   = out_v[i][CS];
            prev_sclk[i] = out_v[i][SCK];
            prev_rdy[i]  = out_v[i][RDY];
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Wait (bounded) for an output bit to reach a level; a timeout is a failed check.
    task automatic wait_for(input int i, input int bitpos, input logic level,
                            input int budget, input string name);
        int n = 0;
        while (out_v[i][bitpos] !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(out_v[i][bitpos]), 32'(level));
    endtask

    // Start one frame on instance 0 and release valid after acceptance.
    task automatic send_a(input logic [W-1:0] w, input string name);
        valid_a = 1'b1;
        data_a  = w;
        wait_for(0, CS, 1'b0, 10, name);
        step();
        valid_a = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a  = '0;
        data_b  = '0;
        #1 rst_n = 1'b0;

        // Reset held with valid high: idle outputs, no sclk activity.
        valid_a = 1'b1;
        data_a  = 16'hA5C3;
        repeat (5) step();
        check("reset_outs_a", 32'(out_v[0]), 32'(IDLE_OUT));
        check("reset_outs_b", 32'(out_v[1]), 32'(IDLE_OUT));
        check("reset_sclk_quiet", 32'(sclk_edges[0]), 32'd0);
        valid_a = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Single frame 0xA5C3, H=4.
        send_a(16'hA5C3, "accept_a5c3");
        wait_for(0, DN, 1'b1, 200, "done_a5c3");
        step();
        check("rises_a5c3", 32'(rises[0]), 32'd16);
        check("word_a5c3", 32'(cap[0]), 32'hA5C3);
        check("cs_low_a5c3", 32'(cs_low[0]), 32'd132);
        check("ldac_low_a5c3", 32'(ldac_low[0]), 32'd4);
        check("done_cnt_a5c3", 32'(done_n[0]), 32'd1);
        wait_for(0, RDY, 1'b1, 100, "ready_a5c3");
        step();

        // Back-to-back with valid held: 0x0000 then 0xFFFF.
        valid_a = 1'b1;
        data_a  = 16'h0000;
        wait_for(0, CS, 1'b0, 10, "accept_0000");
        step();
        data_a = 16'hFFFF;
        wait_for(0, DN, 1'b1, 200, "done_0000");
        step();
        check("word_0000", 32'(cap[0]), 32'h0000);
        check("rises_0000", 32'(rises[0]), 32'd16);
        wait_for(0, CS, 1'b0, 50, "accept_ffff");
        step();
        valid_a = 1'b0;
        check("accept_interval", 32'(fall_cyc[0] - prev_fall[0]), 32'd145);
        check("cs_high_gap", 32'(fall_cyc[0] - rise_cyc[0]), 32'd13);
        wait_for(0, DN, 1'b1, 200, "done_ffff");
        step();
        check("word_ffff", 32'(cap[0]), 32'hFFFF);
        wait_for(0, RDY, 1'b1, 100, "ready_ffff");
        step();

        // valid pulsed mid-SHIFT must not disturb frame 0x8001.
        send_a(16'h8001, "accept_8001");
        repeat (40) step();
        valid_a = 1'b1;
        data_a  = 16'h1234;
        step();
        valid_a = 1'b0;
        check("ready_low_midframe", 32'(ready_a), 32'd0);
        wait_for(0, DN, 1'b1, 200, "done_8001");
        step();
        check("word_8001", 32'(cap[0]), 32'h8001);
        wait_for(0, RDY, 1'b1, 100, "ready_8001");
        step();
        check("ready_delay_8001", 32'(rdy_cyc[0] - fall_cyc[0]), 32'd144);

        // Reset pulsed while bit 7 is on the line.
        send_a(16'hF0F0, "accept_f0f0");
        repeat (68) step();
        rst_n = 1'b0;
        #1;
        check("rst_cs_high", 32'(cs_a), 32'd1);
        check("rst_sclk_high", 32'(sclk_a), 32'd1);
        check("rst_ldac_high", 32'(ldac_a), 32'd1);
        check("rst_ready_high", 32'(ready_a), 32'd1);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_no_done", 32'(done_n[0]), 32'd0);
        send_a(16'h00FF, "accept_00ff");
        wait_for(0, DN, 1'b1, 200, "done_00ff");
        step();
        check("word_00ff", 32'(cap[0]), 32'h00FF);
        check("rises_00ff", 32'(rises[0]), 32'd16);
        wait_for(0, RDY, 1'b1, 100, "ready_00ff");

        // H=2 instance, 0x5555.
        valid_b = 1'b1;
        data_b  = 16'h5555;
        wait_for(1, CS, 1'b0, 10, "accept_5555");
        step();
        valid_b = 1'b0;
        wait_for(1, DN, 1'b1, 100, "done_5555");
        step();
        check("word_5555", 32'(cap[1]), 32'h5555);
        check("rises_5555", 32'(rises[1]), 32'd16);
        check("sclk_period_h2", 32'(per[1]), 32'd4);
        check("cs_low_h2", 32'(cs_low[1]), 32'd66);
        check("ldac_low_h2", 32'(ldac_low[1]), 32'd2);
        wait_for(1, RDY, 1'b1, 50, "ready_5555");
        step();
        check("frame_len_h2", 32'(rdy_cyc[1] - fall_cyc[1]), 32'd72);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
